// File: rtl/hit_pair_packer_if.sv
// Dual-lane R18 hit bus: single-lane fragment input side plus paired output side.
// The packer uses the slave view; whatever feeds fragments and consumes pairs uses the master view.
interface hit_pair_packer_if #(
  parameter int SIGFIG = 24,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic                                     halt_RnnnnL;
  logic                                     flush_RnnnnH;
  logic signed [AXIS-1:0][SIGFIG-1:0]       hit_R16S;
  logic        [COLORS-1:0][SIGFIG-1:0]     color_R16U;
  logic                                     hit_valid_R16H;
  logic                                     hit_ready_R16H;
  logic signed [1:0][AXIS-1:0][SIGFIG-1:0]  hit_R18S;
  logic        [1:0][COLORS-1:0][SIGFIG-1:0] color_R18U;
  logic        [1:0]                        hit_valid_R18H;
  logic                                     empty_RnnnnH;

  modport master (
    output halt_RnnnnL,
    output flush_RnnnnH,
    output hit_R16S,
    output color_R16U,
    output hit_valid_R16H,
    input  hit_ready_R16H,
    input  hit_R18S,
    input  color_R18U,
    input  hit_valid_R18H,
    input  empty_RnnnnH
  );

  modport slave (
    input  halt_RnnnnL,
    input  flush_RnnnnH,
    input  hit_R16S,
    input  color_R16U,
    input  hit_valid_R16H,
    output hit_ready_R16H,
    output hit_R18S,
    output color_R18U,
    output hit_valid_R18H,
    output empty_RnnnnH
  );
endinterface

// File: rtl/hit_pair_packer.sv
// Packs a single-lane fragment stream into dual-lane hits for the z-buffer.
// Two fragments share a cycle only when every color channel matches, since the z-buffer reads lane 0 color only.
module hit_pair_packer #(
  parameter int SIGFIG  = 24,
  parameter int RADIX   = 10,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  hit_pair_packer_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  if (TIMEOUT < 1 || TIMEOUT > 255 || RADIX < 0 || RADIX > SIGFIG) begin : g_bad_param
    $error("hit_pair_packer: TIMEOUT must be 1..255 and RADIX must fit in SIGFIG");
  end

  typedef logic signed [AXIS-1:0][SIGFIG-1:0]       hit_t;
  typedef logic        [COLORS-1:0][SIGFIG-1:0]     col_t;
  typedef logic signed [1:0][AXIS-1:0][SIGFIG-1:0]  hit_pair_t;
  typedef logic        [1:0][COLORS-1:0][SIGFIG-1:0] col_pair_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t     state_q, state_n;
  hit_t       hold_hit_q, hold_hit_n;
  col_t       hold_col_q, hold_col_n;
  logic [TW-1:0] timer_q, timer_n;
  hit_pair_t  out_hit_q, out_hit_n;
  col_pair_t  out_col_q, out_col_n;
  logic [1:0] out_valid_q, out_valid_n;

  logic colors_match;
  logic timer_expired;

  assign colors_match  = (bus.color_R16U == hold_col_q);
  assign timer_expired = (timer_q == TIMER_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      hold_hit_q  <= '0;
      hold_col_q  <= '0;
      timer_q     <= '0;
      out_hit_q   <= '0;
      out_col_q   <= '0;
      out_valid_q <= 2'b00;
    end else begin
      state_q     <= state_n;
      hold_hit_q  <= hold_hit_n;
      hold_col_q  <= hold_col_n;
      timer_q     <= timer_n;
      out_hit_q   <= out_hit_n;
      out_col_q   <= out_col_n;
      out_valid_q <= out_valid_n;
    end
  end

  // Halt freezes everything; the held fragment leaves on pairing, mismatch, flush or timeout, in that priority.
  always_comb begin
    state_n     = state_q;
    hold_hit_n  = hold_hit_q;
    hold_col_n  = hold_col_q;
    timer_n     = timer_q;
    out_hit_n   = out_hit_q;
    out_col_n   = out_col_q;
    out_valid_n = 2'b00;

    if (bus.halt_RnnnnL) begin
      case (state_q)
        EMPTY: begin
          if (bus.hit_valid_R16H) begin
            hold_hit_n = bus.hit_R16S;
            hold_col_n = bus.color_R16U;
            timer_n    = '0;
            state_n    = HELD;
          end
        end
        HELD: begin
          if (bus.hit_valid_R16H && colors_match) begin
            out_valid_n  = 2'b11;
            out_hit_n[0] = hold_hit_q;
            out_col_n[0] = hold_col_q;
            out_hit_n[1] = bus.hit_R16S;
            out_col_n[1] = bus.color_R16U;
            timer_n      = '0;
            state_n      = EMPTY;
          end else if (bus.hit_valid_R16H) begin
            out_valid_n  = 2'b01;
            out_hit_n[0] = hold_hit_q;
            out_col_n[0] = hold_col_q;
            hold_hit_n   = bus.hit_R16S;
            hold_col_n   = bus.color_R16U;
            timer_n      = '0;
          end else if (bus.flush_RnnnnH || timer_expired) begin
            out_valid_n  = 2'b01;
            out_hit_n[0] = hold_hit_q;
            out_col_n[0] = hold_col_q;
            timer_n      = '0;
            state_n      = EMPTY;
          end else begin
            timer_n = timer_q + TW'(1);
          end
        end
        default: begin
          state_n = EMPTY;
        end
      endcase
    end
  end

  assign bus.hit_ready_R16H = bus.halt_RnnnnL;
  assign bus.empty_RnnnnH   = (state_q == EMPTY);
  assign bus.hit_R18S       = out_hit_q;
  assign bus.color_R18U     = out_col_q;
  assign bus.hit_valid_R18H = out_valid_q;

endmodule
